// File: rtl/dds_wave_gen.sv
// ============================================================================
//  Module   : dds_wave_gen
//  Purpose  : Direct digital synthesis waveform generator. A phase
//             accumulator advances by the active frequency tuning word every
//             clock. Its top 8 bits are mapped to a sine, square, triangle or
//             sawtooth sample. The sample is registered onto wave_out_o.
//  Ports    : clk          system clock, rising edge
//             rst          synchronous active-high reset
//             fre_word_i   tuning word, f_out = fre_word * f_clk / 2^ACC_W
//             wave_sel_i   00 sine, 01 square, 10 triangle, 11 sawtooth
//             fre_load_i   one-cycle strobe capturing fre_word_i/wave_sel_i
//             upd_done_o   pulses in the cycle a captured setting goes active
//             wrap_o       pulses in the cycle the accumulator has carried out
//             wave_out_o   registered unsigned 8-bit sample
//  Options  : DDS_WRAP_UPDATE_EN -- when defined, a loaded setting waits
//             for the next accumulator carry, so the waveform changes at a
//             phase-wrap boundary. When undefined, a loaded setting is
//             applied on the edge that samples the strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dds_wave_gen #(
  parameter int unsigned      ACC_W   = 32,  // 16..32
  parameter logic [ACC_W-1:0] FTW_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ACC_W-1:0] fre_word_i,
  input  logic [1:0]       wave_sel_i,
  input  logic             fre_load_i,
  output logic             upd_done_o,
  output logic             wrap_o,
  output logic [7:0]       wave_out_o
);

  localparam logic [1:0] C_SEL_SINE   = 2'b00;
  localparam logic [1:0] C_SEL_SQUARE = 2'b01;
  localparam logic [1:0] C_SEL_TRI    = 2'b10;
  localparam logic [1:0] C_SEL_SAW    = 2'b11;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] ftw_act_q, ftw_act_d;
  logic [ACC_W-1:0] ftw_pend_q, ftw_pend_d;
  logic [1:0]       sel_act_q, sel_act_d;
  logic [1:0]       sel_pend_q, sel_pend_d;
  logic             pend_q, pend_d;
  logic             upd_done_q, upd_done_d;
  logic             wrap_q, wrap_d;
  logic [7:0]       wave_q, wave_d;

  logic [ACC_W:0]   w_sum;
  logic [7:0]       w_idx;
  logic [7:0]       w_sample;

  // First quarter of round(127.5 + 127.5*sin(2*pi*k/256)), k = 0..64.
  function automatic logic [7:0] sine_quarter(input logic [6:0] j);
    logic [7:0] v;
    case (j)
      7'd0:  v = 8'd128;  7'd1:  v = 8'd131;  7'd2:  v = 8'd134;  7'd3:  v = 8'd137;
      7'd4:  v = 8'd140;  7'd5:  v = 8'd143;  7'd6:  v = 8'd146;  7'd7:  v = 8'd149;
      7'd8:  v = 8'd152;  7'd9:  v = 8'd155;  7'd10: v = 8'd158;  7'd11: v = 8'd162;
      7'd12: v = 8'd165;  7'd13: v = 8'd167;  7'd14: v = 8'd170;  7'd15: v = 8'd173;
      7'd16: v = 8'd176;  7'd17: v = 8'd179;  7'd18: v = 8'd182;  7'd19: v = 8'd185;
      7'd20: v = 8'd188;  7'd21: v = 8'd190;  7'd22: v = 8'd193;  7'd23: v = 8'd196;
      7'd24: v = 8'd198;  7'd25: v = 8'd201;  7'd26: v = 8'd203;  7'd27: v = 8'd206;
      7'd28: v = 8'd208;  7'd29: v = 8'd211;  7'd30: v = 8'd213;  7'd31: v = 8'd215;
      7'd32: v = 8'd218;  7'd33: v = 8'd220;  7'd34: v = 8'd222;  7'd35: v = 8'd224;
      7'd36: v = 8'd226;  7'd37: v = 8'd228;  7'd38: v = 8'd230;  7'd39: v = 8'd232;
      7'd40: v = 8'd234;  7'd41: v = 8'd235;  7'd42: v = 8'd237;  7'd43: v = 8'd238;
      7'd44: v = 8'd240;  7'd45: v = 8'd241;  7'd46: v = 8'd243;  7'd47: v = 8'd244;
      7'd48: v = 8'd245;  7'd49: v = 8'd246;  7'd50: v = 8'd248;  7'd51: v = 8'd249;
      7'd52: v = 8'd250;  7'd53: v = 8'd250;  7'd54: v = 8'd251;  7'd55: v = 8'd252;
      7'd56: v = 8'd253;  7'd57: v = 8'd253;  7'd58: v = 8'd254;  7'd59: v = 8'd254;
      7'd60: v = 8'd254;  7'd61: v = 8'd255;  7'd62: v = 8'd255;  7'd63: v = 8'd255;
      default: v = 8'd255;  // j = 64, the peak
    endcase
    return v;
  endfunction

  // Full-wave sine by symmetry folding. The second half mirrors the first
  // around 127.5. That gives 255 - q everywhere except k = 128, where the
  // exact value is 127.5 and rounds up to 128, just like k = 0.
  function automatic logic [7:0] sine_lut(input logic [7:0] k);
    logic [6:0] m;
    logic [6:0] j;
    logic [7:0] q;
    logic [7:0] v;
    m = k[6:0];
    if (m > 7'd64) begin
      j = 7'(8'd128 - {1'b0, m});
    end else begin
      j = m;
    end
    q = sine_quarter(j);
    if (!k[7]) begin
      v = q;
    end else if (m == 7'd0) begin
      v = 8'd128;
    end else begin
      v = 8'd255 - q;
    end
    return v;
  endfunction

  assign w_sum = {1'b0, acc_q} + {1'b0, ftw_act_q};
  assign w_idx = acc_q[ACC_W-1 -: 8];

  always_comb begin
    w_sample = w_idx;
    case (sel_act_q)
      C_SEL_SINE:   w_sample = sine_lut(w_idx);
      C_SEL_SQUARE: w_sample = w_idx[7] ? 8'd0 : 8'd255;
      C_SEL_TRI:    w_sample = w_idx[7] ? ~{w_idx[6:0], 1'b0} : {w_idx[6:0], 1'b0};
      C_SEL_SAW:    w_sample = w_idx;
      default:      w_sample = w_idx;
    endcase
  end

  always_comb begin
    acc_d      = w_sum[ACC_W-1:0];
    wrap_d     = w_sum[ACC_W];
    wave_d     = w_sample;
    ftw_act_d  = ftw_act_q;
    sel_act_d  = sel_act_q;
    ftw_pend_d = ftw_pend_q;
    sel_pend_d = sel_pend_q;
    pend_d     = pend_q;
    upd_done_d = 1'b0;

`ifdef DDS_WRAP_UPDATE_EN
    if (fre_load_i) begin
      ftw_pend_d = fre_word_i;
      sel_pend_d = wave_sel_i;
      if (ftw_act_q == '0) begin
        // A stopped accumulator never carries, so it cannot wait for a wrap.
        ftw_act_d  = fre_word_i;
        sel_act_d  = wave_sel_i;
        pend_d     = 1'b0;
        upd_done_d = 1'b1;
      end else begin
        // A load on the carry edge itself is held until the following wrap.
        pend_d = 1'b1;
      end
    end else if (pend_q && (w_sum[ACC_W] || (ftw_act_q == '0))) begin
      ftw_act_d  = ftw_pend_q;
      sel_act_d  = sel_pend_q;
      pend_d     = 1'b0;
      upd_done_d = 1'b1;
    end
`else
    if (fre_load_i) begin
      ftw_pend_d = fre_word_i;
      sel_pend_d = wave_sel_i;
      ftw_act_d  = fre_word_i;
      sel_act_d  = wave_sel_i;
      pend_d     = 1'b0;
      upd_done_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      ftw_act_q  <= FTW_RST;
      sel_act_q  <= C_SEL_SINE;
      ftw_pend_q <= '0;
      sel_pend_q <= 2'b00;
      pend_q     <= 1'b0;
      upd_done_q <= 1'b0;
      wrap_q     <= 1'b0;
      wave_q     <= 8'd0;
    end else begin
      acc_q      <= acc_d;
      ftw_act_q  <= ftw_act_d;
      sel_act_q  <= sel_act_d;
      ftw_pend_q <= ftw_pend_d;
      sel_pend_q <= sel_pend_d;
      pend_q     <= pend_d;
      upd_done_q <= upd_done_d;
      wrap_q     <= wrap_d;
      wave_q     <= wave_d;
    end
  end

  assign upd_done_o = upd_done_q;
  assign wrap_o     = wrap_q;
  assign wave_out_o = wave_q;

endmodule

`default_nettype wire

// File: tb/tb_dds_wave_gen.sv
// ============================================================================
//  Module   : tb_dds_wave_gen
//  Purpose  : Directed, table-driven self-checking bench for dds_wave_gen
//             (ACC_W = 32). Each table row resets the generator, loads one
//             setting and samples the output N cycles after the load. Hand
//             sequences cover mid-period reloads, double loads and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dds_wave_gen;

  logic        clk;
  logic        rst;
  logic [31:0] fre_word;
  logic [1:0]  wave_sel;
  logic        fre_load;
  logic        upd_done;
  logic        wrap;
  logic [7:0]  wave_out;

  int n_tests;
  int n_fail;

  dds_wave_gen #(.ACC_W(32), .FTW_RST(32'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .fre_word_i (fre_word),
    .wave_sel_i (wave_sel),
    .fre_load_i (fre_load),
    .upd_done_o (upd_done),
    .wrap_o     (wrap),
    .wave_out_o (wave_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [1:0]  sel;
    logic [31:0] ftw;
    int          ncyc;      // cycles after the load edge before sampling
    logic [7:0]  exp_wave;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[26];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [31:0] ftw, input logic [1:0] sel);
    fre_word = ftw;
    wave_sel = sel;
    fre_load = 1'b1;
    tick();
    fre_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1, w2, w3, wp;
    int         cnt;
    bit         seen;
    bit         step_ok;

    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    fre_word = '0;
    wave_sel = 2'b00;
    fre_load = 1'b0;

    //                name          sel    ftw         N    wave  wrap
    vecs[0]  = '{"saw_n1",     2'b11, 32'h0100_0000,   1,   0, 1'b0};
    vecs[1]  = '{"saw_n101",   2'b11, 32'h0100_0000, 101, 100, 1'b0};
    vecs[2]  = '{"saw_n256",   2'b11, 32'h0100_0000, 256, 255, 1'b1};
    vecs[3]  = '{"saw_n257",   2'b11, 32'h0100_0000, 257,   0, 1'b0};
    vecs[4]  = '{"sin_i0",     2'b00, 32'h0100_0000,   1, 128, 1'b0};
    vecs[5]  = '{"sin_i11",    2'b00, 32'h0100_0000,  12, 162, 1'b0};
    vecs[6]  = '{"sin_i13",    2'b00, 32'h0100_0000,  14, 167, 1'b0};
    vecs[7]  = '{"sin_i32",    2'b00, 32'h0100_0000,  33, 218, 1'b0};
    vecs[8]  = '{"sin_i64",    2'b00, 32'h0100_0000,  65, 255, 1'b0};
    vecs[9]  = '{"sin_i96",    2'b00, 32'h0100_0000,  97, 218, 1'b0};
    vecs[10] = '{"sin_i128",   2'b00, 32'h0100_0000, 129, 128, 1'b0};
    vecs[11] = '{"sin_i160",   2'b00, 32'h0100_0000, 161,  37, 1'b0};
    vecs[12] = '{"sin_i192",   2'b00, 32'h0100_0000, 193,   0, 1'b0};
    vecs[13] = '{"sin_i241",   2'b00, 32'h0100_0000, 242,  82, 1'b0};
    vecs[14] = '{"sq_n1",      2'b01, 32'h0200_0000,   1, 255, 1'b0};
    vecs[15] = '{"sq_n64",     2'b01, 32'h0200_0000,  64, 255, 1'b0};
    vecs[16] = '{"sq_n65",     2'b01, 32'h0200_0000,  65,   0, 1'b0};
    vecs[17] = '{"sq_n128",    2'b01, 32'h0200_0000, 128,   0, 1'b1};
    vecs[18] = '{"sq_n129",    2'b01, 32'h0200_0000, 129, 255, 1'b0};
    vecs[19] = '{"tri_i0",     2'b10, 32'h0100_0000,   1,   0, 1'b0};
    vecs[20] = '{"tri_i64",    2'b10, 32'h0100_0000,  65, 128, 1'b0};
    vecs[21] = '{"tri_i127",   2'b10, 32'h0100_0000, 128, 254, 1'b0};
    vecs[22] = '{"tri_i128",   2'b10, 32'h0100_0000, 129, 255, 1'b0};
    vecs[23] = '{"tri_i192",   2'b10, 32'h0100_0000, 193, 127, 1'b0};
    vecs[24] = '{"tri_i255",   2'b10, 32'h0100_0000, 256,   1, 1'b1};
    vecs[25] = '{"ftw_zero",   2'b11, 32'h0000_0000,  50,   0, 1'b0};

    // Reset state.
    repeat (2) tick();
    rst = 1'b0;
    check("rst_wave", 32'(wave_out), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    check("rst_upd",  32'(upd_done), 32'd0);

    // Table-driven single-setting vectors. The setting follows a reset, so the
    // active tuning word is 0 and the load takes effect at once in both modes.
    for (int i = 0; i < 26; i++) begin
      do_reset();
      load(vecs[i].ftw, vecs[i].sel);
      check({vecs[i].name, "_upd"}, 32'(upd_done), 32'd1);
      repeat (vecs[i].ncyc) tick();
      check({vecs[i].name, "_wave"}, 32'(wave_out), 32'(vecs[i].exp_wave));
      check({vecs[i].name, "_wrap"}, 32'(wrap), 32'(vecs[i].exp_wrap));
    end

    // Mid-period reload from 2^24 to 2^25 on a sawtooth.
    do_reset();
    load(32'h0100_0000, 2'b11);
    repeat (100) tick();
    load(32'h0200_0000, 2'b11);
`ifdef DDS_WRAP_UPDATE_EN
    check("mid_upd_not_yet", 32'(upd_done), 32'd0);
    cnt     = 0;
    seen    = 1'b0;
    step_ok = 1'b1;
    wp      = wave_out;
    while (!seen && cnt < 300) begin
      tick();
      cnt++;
      if (upd_done) seen = 1'b1;
      else if (wave_out != 8'(wp + 8'd1)) step_ok = 1'b0;
      wp = wave_out;
    end
    check("mid_upd_cycles", 32'(cnt), 32'd155);
    check("mid_upd_with_wrap", 32'(wrap), 32'd1);
    check("mid_no_glitch", 32'(step_ok), 32'd1);
    tick();
    tick();
    check("mid_new_step", 32'(wave_out), 32'd2);
`else
    check("mid_upd_next", 32'(upd_done), 32'd1);
    w1 = wave_out;
    tick();
    w2 = wave_out;
    tick();
    w3 = wave_out;
    check("mid_w1", 32'(w1), 32'd100);
    check("mid_w2", 32'(w2), 32'd101);
    check("mid_w3", 32'(w3), 32'd103);
`endif

    // Two loads three cycles apart; the second value must end up active.
    do_reset();
    load(32'h0100_0000, 2'b11);
    repeat (20) tick();
    cnt = 0;
    load(32'h0200_0000, 2'b11);
    if (upd_done) cnt++;
    repeat (2) begin
      tick();
      if (upd_done) cnt++;
    end
    load(32'h0400_0000, 2'b11);
    if (upd_done) cnt++;
    repeat (300) begin
      tick();
      if (upd_done) cnt++;
    end
`ifdef DDS_WRAP_UPDATE_EN
    check("dbl_upd_count", 32'(cnt), 32'd1);
`else
    check("dbl_upd_count", 32'(cnt), 32'd2);
`endif
    w1 = wave_out;
    tick();
    w2 = wave_out;
    check("dbl_final_step", 32'(8'(w2 - w1)), 32'd4);

    // Reset mid-ramp.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_wave", 32'(wave_out), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    check("midrst_acc",  dut.acc_q, 32'd0);
    check("midrst_pend", 32'(dut.pend_q), 32'd0);

    // Load together with reset: reset wins, the accumulator stays stopped.
    rst      = 1'b1;
    fre_word = 32'h0100_0000;
    wave_sel = 2'b11;
    fre_load = 1'b1;
    tick();
    rst      = 1'b0;
    fre_load = 1'b0;
    check("rstload_upd", 32'(upd_done), 32'd0);
    repeat (5) tick();
    check("rstload_acc",  dut.acc_q, 32'd0);
    check("rstload_wave", 32'(wave_out), 32'd128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dds_wave_gen.md
# dds_wave_gen

Direct digital synthesis waveform generator that produces the 8-bit `wave_out` sample stream consumed by the downstream real-frequency measurement stage. A phase accumulator advances by a loadable frequency tuning word every `clk`. The top phase bits are mapped to sine, square, triangle or sawtooth. New tuning word and waveform selection are taken through a single-cycle load strobe and applied either immediately or glitch-free at phase wrap.

## Interface
- `ACC_W`, 32: phase accumulator width in bits; allowed range 16–32.
- `FTW_RST`, 0: tuning word loaded at reset.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fre_word`  in  ACC_W  tuning word; output frequency = fre_word·f_clk/2^ACC_W.
- `wave_sel`  in  2  waveform: 00 sine, 01 square, 10 triangle, 11 sawtooth.
- `fre_load`  in  1  one-cycle strobe; captures `fre_word` and `wave_sel`.
- `upd_done`  out  1  one-cycle pulse in the cycle a captured setting becomes active.
- `wrap`  out  1  one-cycle pulse when the accumulator carries out.
- `wave_out`  out  8  unsigned sample, registered.

## Operation
- State registers:
  - `acc[ACC_W-1:0]`
  - `ftw_act`
  - `sel_act`
  - `ftw_pend`
  - `sel_pend`
  - `pend` flag
- Reset values:
  - `acc` = 0, `ftw_act` = FTW_RST, `sel_act` = 00, `pend` = 0.
  - `wave_out` = 0, `wrap` = 0, `upd_done` = 0.
- Every non-reset cycle: `acc <= acc + ftw_act`, modulo 2^ACC_W.
  - `wrap <= 1` if the (ACC_W+1)-bit sum carries; otherwise 0.
- Phase index: `idx = acc[ACC_W-1 -: 8]`, taken before the update.
- Sample map, registered into `wave_out`:
  - Sawtooth: `idx`.
  - Square: 8'd255 when `idx[7]==0`, else 8'd0.
  - Triangle: `{idx[6:0],1'b0}` when `idx[7]==0`, else `~{idx[6:0],1'b0}`.
  - Sine: LUT[k] = round(127.5 + 127.5·sin(2πk/256)), so LUT[0]=128, LUT[64]=255, LUT[192]=0. A full 256-entry ROM or a quarter-wave ROM with symmetry folding is acceptable; the output must be bit-identical.
- Load:
  - `fre_load` writes `ftw_pend`/`sel_pend` and sets `pend`.
  - A second load while `pend` is set overwrites the pending values. Only the last one is applied, with a single `upd_done`.
- Apply:
  - Copies pending into active, clears `pend`, pulses `upd_done`.
  - Apply time depends on the configuration (see below).
- `ftw_act == 0` holds `acc` constant, so `wave_out` is a constant sample and `wrap` stays 0.

## Timing
- Latency:
  - `acc` at edge n determines `wave_out` at edge n+1.
  - A new active setting affects `acc` increments from the cycle after `upd_done`.
- `wrap` is asserted in the same cycle `acc` holds the wrapped value. `wave_out` reflects that value one cycle later.
- `fre_load` asserted in the same cycle as `rst`: reset wins; the load is lost.
- Reset mid-operation: all registers return to reset values on the next edge; any pending update is discarded.
- Output period for power-of-two tuning words: 2^ACC_W / fre_word cycles, exact.

## Configuration
- Macro: `DDS_WRAP_UPDATE_EN`.
- Defined (glitch-free update):
  - A pending setting is applied on the edge where the accumulator carries out, i.e. together with `wrap`.
  - The setting must have been pending before that cycle. A load arriving in the wrap cycle waits for the next wrap.
  - Exception: if `ftw_act == 0`, the setting is applied on the cycle after the load, so there is no deadlock.
- Undefined (immediate update):
  - The setting is applied on the cycle after `fre_load`; `upd_done` pulses that cycle.
  - `wrap` has no role in updates.
- The phase accumulator is never cleared by an update in either mode.

## Test plan
- Reset, then load `fre_word`=2^24, `wave_sel`=11 (ACC_W=32):
  - `wave_out` ramps 0,1,2,…,255 one step per cycle.
  - `wrap` pulses every 256 cycles.
- Same tuning word, `wave_sel`=00:
  - `wave_out` sequence starts 128, peaks at 255 at idx 64, reaches 0 at idx 192.
  - Full period is 256 cycles.
- `wave_sel`=01, `fre_word`=2^25:
  - 64 cycles at 255 then 64 cycles at 0, repeating.
  - The downstream measurement stage counts 390625 rising edges per 1 s gate at 50 MHz.
- With `DDS_WRAP_UPDATE_EN`, running at 2^24, load 2^25 mid-period:
  - `upd_done` coincides with the next `wrap`.
  - No sawtooth discontinuity occurs before that point.
- Without the macro, the same stimulus gives `upd_done` exactly one cycle after `fre_load`.
- Two loads 3 cycles apart before a wrap give one `upd_done` and the second value active. Assert `rst` for one cycle mid-ramp: the next cycle shows `wave_out`=0, `acc`=0 and `pend`=0.
